// File: rtl/cpu_ctrl_pkg.sv
// Shared decode-stage definitions: opcode classes, control-bundle bit positions,
// stage state encoding and the flush-counter sizing helper.
package cpu_ctrl_pkg;

  localparam logic [1:0] CLS_LDA = 2'b00;
  localparam logic [1:0] CLS_STA = 2'b01;
  localparam logic [1:0] CLS_IMM = 2'b10;
  localparam logic [1:0] CLS_BAF = 2'b11;

  localparam int unsigned CTRL_W       = 7;
  localparam int unsigned BIT_BRANCH   = 6;
  localparam int unsigned BIT_FLUSH    = 5;
  localparam int unsigned BIT_REGWRITE = 4;
  localparam int unsigned BIT_MEMWRITE = 3;
  localparam int unsigned BIT_MEMTOREG = 2;
  localparam int unsigned BIT_IMMED    = 1;
  localparam int unsigned BIT_FORWARD  = 0;

  typedef logic [CTRL_W-1:0] ctrl_bundle_t;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  // Flush counter must hold FLUSH_CYCLES; keep at least one bit when flushing is disabled.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n == 0) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/opcode_class_lut.sv
// Combinational opcode-class to control-bundle table.
module opcode_class_lut
  import cpu_ctrl_pkg::*;
(
  input  logic [1:0]   i_class,
  output ctrl_bundle_t o_bundle
);

  always_comb begin
    o_bundle = '0;
    unique case (i_class)
      CLS_LDA: begin
        o_bundle[BIT_REGWRITE] = 1'b1;
        o_bundle[BIT_MEMTOREG] = 1'b1;
        o_bundle[BIT_IMMED]    = 1'b1;
        o_bundle[BIT_FORWARD]  = 1'b1;
      end
      CLS_STA: begin
        o_bundle[BIT_MEMWRITE] = 1'b1;
      end
      CLS_IMM: begin
        o_bundle[BIT_REGWRITE] = 1'b1;
        o_bundle[BIT_IMMED]    = 1'b1;
        o_bundle[BIT_FORWARD]  = 1'b1;
      end
      CLS_BAF: begin
        o_bundle[BIT_BRANCH]   = 1'b1;
        o_bundle[BIT_FLUSH]    = 1'b1;
      end
      default: o_bundle = '0;
    endcase
  end

endmodule

// File: rtl/ctrl_decode_stage.sv
// Registered decode stage: class decode into a one-deep output register with
// valid/ready, load-use bubble insertion and counted branch-shadow flush.
module ctrl_decode_stage
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned OPC_W        = 4,
  parameter int unsigned REG_W        = 3,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [OPC_W-1:0] i_opcode,
  input  logic [REG_W-1:0] i_rd,
  input  logic [REG_W-1:0] i_rs1,
  input  logic [REG_W-1:0] i_rs2,
  input  logic             i_branch_taken,
  input  logic             i_ready,
  output logic             o_valid,
  output logic             o_branch,
  output logic             o_flush,
  output logic             o_regwrite,
  output logic             o_memwrite,
  output logic             o_memtoreg,
  output logic             o_immediate,
  output logic             o_forward,
  output logic [OPC_W-3:0] o_alufunc,
  output logic [REG_W-1:0] o_rd,
  output logic             o_stall
);

  localparam int unsigned      CNT_W      = cnt_width(FLUSH_CYCLES);
  localparam logic [CNT_W-1:0] FLUSH_INIT = CNT_W'(FLUSH_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_valid;
  ctrl_bundle_t     r_bundle;
  logic [OPC_W-3:0] r_alufunc;
  logic [REG_W-1:0] r_rd;

  ctrl_bundle_t     w_bundle;
  logic             w_out_free;
  logic             w_load_use;
  logic             w_accept;

  opcode_class_lut u_lut (
    .i_class  (i_opcode[OPC_W-1:OPC_W-2]),
    .o_bundle (w_bundle)
  );

  assign w_out_free = !r_valid || i_ready;
  assign w_load_use = r_valid && r_bundle[BIT_MEMTOREG] && i_valid &&
                      ((r_rd == i_rs1) || (r_rd == i_rs2));

  always_comb begin
    o_ready = 1'b1;
    o_stall = 1'b0;
    if (r_state == ST_RUN) begin
      o_ready = w_out_free && !w_load_use;
      o_stall = w_load_use && i_ready;
    end
  end

  assign w_accept = i_valid && o_ready;

  // Branch beats everything; in FLUSH every offered instruction is consumed and dropped.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_RUN;
      r_cnt     <= '0;
      r_valid   <= 1'b0;
      r_bundle  <= '0;
      r_alufunc <= '0;
      r_rd      <= '0;
    end else if (i_branch_taken) begin
      r_valid <= 1'b0;
      r_cnt   <= FLUSH_INIT;
      r_state <= (FLUSH_CYCLES == 0) ? ST_RUN : ST_FLUSH;
    end else if (r_state == ST_FLUSH) begin
      r_valid <= 1'b0;
      if (i_valid) begin
        if (r_cnt > CNT_ONE) begin
          r_cnt <= r_cnt - CNT_ONE;
        end else begin
          r_cnt   <= '0;
          r_state <= ST_RUN;
        end
      end
    end else if (w_out_free) begin
      if (w_accept) begin
        r_valid   <= 1'b1;
        r_bundle  <= w_bundle;
        r_alufunc <= i_opcode[OPC_W-3:0];
        r_rd      <= i_rd;
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_valid     = r_valid;
  assign o_branch    = r_bundle[BIT_BRANCH];
  assign o_flush     = r_bundle[BIT_FLUSH];
  assign o_regwrite  = r_bundle[BIT_REGWRITE];
  assign o_memwrite  = r_bundle[BIT_MEMWRITE];
  assign o_memtoreg  = r_bundle[BIT_MEMTOREG];
  assign o_immediate = r_bundle[BIT_IMMED];
  assign o_forward   = r_bundle[BIT_FORWARD];
  assign o_alufunc   = r_alufunc;
  assign o_rd        = r_rd;

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Scoreboard bench for ctrl_decode_stage: emitted instructions are predicted at
// accept time and checked when the output register hands them downstream.
module tb_ctrl_decode_stage;

  logic       clk = 1'b0;
  logic       i_rst_n;
  logic       i_valid;
  logic       o_ready;
  logic [3:0] i_opcode;
  logic [2:0] i_rd, i_rs1, i_rs2;
  logic       i_branch_taken;
  logic       i_ready;
  logic       o_valid;
  logic       o_branch, o_flush, o_regwrite, o_memwrite, o_memtoreg, o_immediate, o_forward;
  logic [1:0] o_alufunc;
  logic [2:0] o_rd;
  logic       o_stall;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;
  logic [11:0] sb[$];
  logic [11:0] w_obs;

  always #5 clk = ~clk;

  ctrl_decode_stage #(.OPC_W(4), .REG_W(3), .FLUSH_CYCLES(2)) dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_opcode(i_opcode), .i_rd(i_rd), .i_rs1(i_rs1), .i_rs2(i_rs2),
    .i_branch_taken(i_branch_taken), .i_ready(i_ready), .o_valid(o_valid),
    .o_branch(o_branch), .o_flush(o_flush), .o_regwrite(o_regwrite),
    .o_memwrite(o_memwrite), .o_memtoreg(o_memtoreg), .o_immediate(o_immediate),
    .o_forward(o_forward), .o_alufunc(o_alufunc), .o_rd(o_rd), .o_stall(o_stall)
  );

  assign w_obs = {o_branch, o_flush, o_regwrite, o_memwrite, o_memtoreg,
                  o_immediate, o_forward, o_alufunc, o_rd};

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] exp_entry(input logic [3:0] opc, input logic [2:0] rd);
    logic [6:0] b;
    case (opc[3:2])
      2'b00:   b = 7'b0010111;
      2'b01:   b = 7'b0001000;
      2'b10:   b = 7'b0010011;
      default: b = 7'b1100000;
    endcase
    return {b, opc[1:0], rd};
  endfunction

  // Output consumer: every downstream transfer must match the oldest prediction.
  always @(negedge clk) begin
    if (i_rst_n && o_valid && i_ready) begin
      if (sb.size() == 0) chk_val("sb_underflow", 32'(sb.size()), 32'd1);
      else chk_val("out_bundle", 32'(w_obs), 32'(sb.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Offer one instruction until accepted; predict it only if it should emerge.
  task automatic send(input logic [3:0] opc, input logic [2:0] rd,
                      input logic [2:0] rs1, input logic [2:0] rs2, input bit emit);
    bit done = 1'b0;
    i_valid = 1'b1; i_opcode = opc; i_rd = rd; i_rs1 = rs1; i_rs2 = rs2;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (o_ready) begin
        done = 1'b1;
        if (emit) sb.push_back(exp_entry(opc, rd));
      end
      tick();
    end
    i_valid = 1'b0;
    if (!done) chk_val("accept_timeout", 32'(done), 32'd1);
  endtask

  task automatic drain(input string tag);
    repeat (3) tick();
    chk_val(tag, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", n_total, n_bad);
    $fatal(1);
  end

  initial begin
    i_rst_n = 1'b0; i_valid = 1'b0; i_opcode = '0; i_rd = '0; i_rs1 = '0; i_rs2 = '0;
    i_branch_taken = 1'b0; i_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk_val("rst_valid", 32'(o_valid), 32'd0);
    chk_val("rst_bundle", 32'(w_obs), 32'd0);
    chk_val("rst_ready", 32'(o_ready), 32'd1);
    tick();
    i_rst_n = 1'b1;
    tick();

    // Reset while a valid bundle is held downstream
    i_ready = 1'b0;
    send(4'h5, 3'd5, 3'd6, 3'd7, 1'b0);
    @(negedge clk);
    chk_val("mid_pre_valid", 32'(o_valid), 32'd1);
    #1 i_rst_n = 1'b0;
    #1;
    chk_val("mid_rst_valid", 32'(o_valid), 32'd0);
    chk_val("mid_rst_bundle", 32'(w_obs), 32'd0);
    chk_val("mid_rst_stall", 32'(o_stall), 32'd0);
    tick();
    i_rst_n = 1'b1; i_ready = 1'b1;
    @(negedge clk);
    chk_val("post_rst_ready", 32'(o_ready), 32'd1);
    chk_val("post_rst_valid", 32'(o_valid), 32'd0);
    tick();

    // Class sweep
    send(4'h0, 3'd1, 3'd6, 3'd7, 1'b1);
    send(4'h5, 3'd2, 3'd6, 3'd7, 1'b1);
    send(4'hA, 3'd3, 3'd6, 3'd7, 1'b1);
    send(4'hF, 3'd4, 3'd6, 3'd7, 1'b1);
    drain("sweep_drain");

    // Backpressure: LDA held three cycles while the next opcode waits
    send(4'h2, 3'd5, 3'd6, 3'd7, 1'b1);
    i_ready = 1'b0;
    i_valid = 1'b1; i_opcode = 4'h9; i_rd = 3'd1; i_rs1 = 3'd6; i_rs2 = 3'd7;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk_val("bp_valid", 32'(o_valid), 32'd1);
      chk_val("bp_ready", 32'(o_ready), 32'd0);
      chk_val("bp_hold", 32'(w_obs), 32'(exp_entry(4'h2, 3'd5)));
      tick();
    end
    i_ready = 1'b1;
    @(negedge clk);
    chk_val("bp_release_ready", 32'(o_ready), 32'd1);
    sb.push_back(exp_entry(4'h9, 3'd1));
    tick();
    i_valid = 1'b0;
    @(negedge clk);
    chk_val("bp_next_valid", 32'(o_valid), 32'd1);
    drain("bp_drain");

    // Load-use hazard on rs2
    send(4'h0, 3'd3, 3'd6, 3'd7, 1'b1);
    i_valid = 1'b1; i_opcode = 4'hB; i_rd = 3'd2; i_rs1 = 3'd6; i_rs2 = 3'd3;
    @(negedge clk);
    chk_val("lu_stall", 32'(o_stall), 32'd1);
    chk_val("lu_ready", 32'(o_ready), 32'd0);
    tick();
    @(negedge clk);
    chk_val("lu_bubble", 32'(o_valid), 32'd0);
    chk_val("lu_stall_off", 32'(o_stall), 32'd0);
    chk_val("lu_ready_back", 32'(o_ready), 32'd1);
    sb.push_back(exp_entry(4'hB, 3'd2));
    tick();
    i_valid = 1'b0;
    @(negedge clk);
    chk_val("lu_emit", 32'(o_valid), 32'd1);
    drain("lu_drain");

    // No hazard when neither source matches
    send(4'h0, 3'd3, 3'd6, 3'd7, 1'b1);
    i_valid = 1'b1; i_opcode = 4'hB; i_rd = 3'd2; i_rs1 = 3'd4; i_rs2 = 3'd4;
    @(negedge clk);
    chk_val("nolu_stall", 32'(o_stall), 32'd0);
    chk_val("nolu_ready", 32'(o_ready), 32'd1);
    sb.push_back(exp_entry(4'hB, 3'd2));
    tick();
    i_valid = 1'b0;
    drain("nolu_drain");

    // Branch flush with an instruction offered in the branch cycle and an idle gap
    send(4'hA, 3'd2, 3'd6, 3'd7, 1'b1);
    i_branch_taken = 1'b1;
    i_valid = 1'b1; i_opcode = 4'h5; i_rd = 3'd1; i_rs1 = 3'd6; i_rs2 = 3'd7;
    tick();
    i_branch_taken = 1'b0; i_valid = 1'b0;
    @(negedge clk);
    chk_val("br_cleared", 32'(o_valid), 32'd0);
    chk_val("br_flush_ready", 32'(o_ready), 32'd1);
    tick();
    send(4'h8, 3'd1, 3'd6, 3'd7, 1'b0);
    for (int g = 0; g < 3; g++) begin
      @(negedge clk);
      chk_val("fl_gap_valid", 32'(o_valid), 32'd0);
      tick();
    end
    send(4'h9, 3'd2, 3'd6, 3'd7, 1'b0);
    @(negedge clk);
    chk_val("fl_second_dropped", 32'(o_valid), 32'd0);
    tick();
    send(4'hE, 3'd5, 3'd6, 3'd7, 1'b1);
    drain("fl_drain");

    // Branch overriding downstream hold, then a restart during FLUSH
    send(4'h6, 3'd2, 3'd6, 3'd7, 1'b0);
    i_ready = 1'b0; i_branch_taken = 1'b1;
    @(negedge clk);
    chk_val("bb_pre_valid", 32'(o_valid), 32'd1);
    tick();
    i_branch_taken = 1'b0; i_ready = 1'b1;
    @(negedge clk);
    chk_val("bb_override", 32'(o_valid), 32'd0);
    tick();
    send(4'h8, 3'd1, 3'd6, 3'd7, 1'b0);
    i_branch_taken = 1'b1;
    tick();
    i_branch_taken = 1'b0;
    send(4'h9, 3'd1, 3'd6, 3'd7, 1'b0);
    send(4'hA, 3'd1, 3'd6, 3'd7, 1'b0);
    @(negedge clk);
    chk_val("bb_third_dropped", 32'(o_valid), 32'd0);
    tick();
    send(4'hD, 3'd6, 3'd1, 3'd2, 1'b1);
    drain("bb_drain");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
